sfp_div_issuer: RTL

- Initiator and sequencer that drives the SFP sequential divider through its start/busy/valid handshake.
- Accepts one denominator per vector, typically the softmax exponent sum, then streams N numerators through the divider one at a time.
- Returns the quotients on a valid/ready output stream.
- Sits between the SFP accumulator/exponent stage and the output buffer, and owns the divider's control inputs.

---
 rtl/sfp_div_issuer_if.sv | 34 +++
 rtl/sfp_div_issuer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sfp_div_issuer_if.sv
// rtl/sfp_div_issuer_if.sv - handshake bundle between the divide issuer and its neighbours
interface sfp_div_issuer_if #(
  parameter int W = 20
);
  logic         cfg_valid;
  logic [W-1:0] cfg_den;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_num;
  logic         div_start;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic         div_busy;
  logic         div_valid;
  logic [W-1:0] div_val;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;
  logic         done;
  logic         err;

  // issuer side
  modport master (
    input  cfg_valid, cfg_den, in_valid, in_num, div_busy, div_valid, div_val, out_ready,
    output in_ready, div_start, div_a, div_b, out_valid, out_data, busy, done, err
  );

  // environment side: config/numerator source, divider, output sink
  modport slave (
    output cfg_valid, cfg_den, in_valid, in_num, div_busy, div_valid, div_val, out_ready,
    input  in_ready, div_start, div_a, div_b, out_valid, out_data, busy, done, err
  );
endinterface

// File: rtl/sfp_div_issuer.sv
// rtl/sfp_div_issuer.sv - sequences one denominator and N numerators through the sequential divider
module sfp_div_issuer #(
  parameter int W       = 20,
  parameter int N       = 8,
  parameter int TIMEOUT = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  sfp_div_issuer_if.master bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [TW-1:0] tcnt;
  logic [W-1:0]  div_a_q;
  logic [W-1:0]  div_b_q;
  logic [W-1:0]  out_data_q;
  logic          div_start_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          err_q;

  logic          in_ready_c;
  logic          in_fire;
  logic          out_fire;
  logic          capture;
  logic          timed_out;
  logic          last_elem;
  logic          den_zero;

  // A numerator is only taken when the single output slot is free or empties this cycle
  assign in_ready_c = (state == S_FETCH) && (!out_valid_q || bus.out_ready);
  assign in_fire    = in_ready_c && bus.in_valid;
  assign out_fire   = out_valid_q && bus.out_ready;
  assign capture    = (state == S_WAIT) && bus.div_valid && !bus.div_busy;
  assign timed_out  = (state == S_WAIT) && !capture && (tcnt == TW'(TIMEOUT - 1));
  assign last_elem  = (count == CW'(N - 1));
  assign den_zero   = (div_b_q == '0);

  // Control FSM plus the output slot; all divider controls and results are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      count       <= '0;
      tcnt        <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      out_data_q  <= '0;
      div_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      // a load below in the same cycle overrides this clear
      if (out_fire) begin
        out_valid_q <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (bus.cfg_valid) begin
            div_b_q <= bus.cfg_den;
            count   <= '0;
            err_q   <= 1'b0;
            state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (in_fire) begin
            if (!den_zero) begin
              div_a_q     <= bus.in_num;
              div_start_q <= 1'b1;
              state       <= S_ISSUE;
            end else begin
              // divide-by-zero never reaches the divider; saturate instead
              out_data_q  <= '1;
              out_valid_q <= 1'b1;
              out_last_q  <= last_elem;
              err_q       <= 1'b1;
              if (last_elem) begin
                state <= S_DRAIN;
              end else begin
                count <= count + CW'(1);
              end
            end
          end
        end
        S_ISSUE: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (capture || timed_out) begin
            out_data_q  <= capture ? bus.div_val : '1;
            out_valid_q <= 1'b1;
            out_last_q  <= last_elem;
            if (timed_out) begin
              err_q <= 1'b1;
            end
            if (last_elem) begin
              state <= S_DRAIN;
            end else begin
              count <= count + CW'(1);
              state <= S_FETCH;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_DRAIN: begin
          if (out_fire) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.div_start = div_start_q;
  assign bus.div_a     = div_a_q;
  assign bus.div_b     = div_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = out_fire && out_last_q;
  assign bus.err       = err_q;

endmodule
